lb_reader: RTL

LB_READER -- requirements
Module: lb_reader

---
 rtl/lb_reader.sv | 83 ++++++++
 1 files changed

// File: rtl/lb_reader.sv
// Line-buffer read FIFO: an 8-deep first-word-fall-through queue that absorbs the rdata stream.
// Optional line framing (out_last on every 64th beat) is enabled by defining LB_READER_LAST_EN.
module lb_reader #(
  parameter int AFULL = 6
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       stall,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overflow,
  output logic [3:0] count
`ifdef LB_READER_LAST_EN
  ,
  output logic       out_last
`endif
);

  logic [7:0] mem [8];
  logic [2:0] wr_ptr;
  logic [2:0] rd_ptr;
  logic       push;
  logic       pop;
  logic       full;

  // A full FIFO still accepts a beat when the head leaves in the same cycle.
  always_comb begin
    full      = (count == 4'd8);
    out_valid = (count != 4'd0);
    pop       = out_valid & out_ready;
    push      = in_valid & (~full | pop);
    stall     = (count >= 4'(AFULL));
    out_data  = mem[rd_ptr];
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr   <= 3'd0;
      rd_ptr   <= 3'd0;
      count    <= 4'd0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 3'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 3'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
      if (in_valid & full & ~pop) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef LB_READER_LAST_EN
  logic [5:0] beat_cnt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      beat_cnt <= 6'd0;
    end else if (pop) begin
      beat_cnt <= beat_cnt + 6'd1;
    end
  end

  assign out_last = out_valid & (beat_cnt == 6'd63);
`endif

endmodule
